// File: rtl/stack_btn_ctrl_if.sv
// stack_btn_ctrl_if: key/command bundle between the button front end and its user.
// The master side drives the raw active-low keys and consumes the commands;
// the slave side is the button controller itself.
interface stack_btn_ctrl_if;
  logic push_btn;
  logic pop_btn;
  logic push;
  logic pop;
  logic push_held;
  logic pop_held;

  modport master (
    output push_btn,
    output pop_btn,
    input  push,
    input  pop,
    input  push_held,
    input  pop_held
  );

  modport slave (
    input  push_btn,
    input  pop_btn,
    output push,
    output pop,
    output push_held,
    output pop_held
  );
endinterface

// File: rtl/stack_btn_ctrl.sv
// stack_btn_ctrl: synchronises and debounces the raw active-low push/pop keys
// and turns each debounced press into one registered single-cycle command,
// never asserting push and pop together.
// Optional auto-repeat of a held key is built only when BTN_AUTOREPEAT_EN is defined.
// Key index 0 is push, key index 1 is pop.
module stack_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 8,
  parameter int CNT_W           = 8
) (
  input logic             clk,
  input logic             reset,
  stack_btn_ctrl_if.slave bus
);
  localparam int NKEYS = 2;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

  // Counters must be able to hold every configured cycle count.
  if ((DEBOUNCE_CYCLES < 2) || (HOLD_CYCLES < 2) || (REPEAT_CYCLES < 1) ||
      ($clog2(DEBOUNCE_CYCLES + 1) > CNT_W) || ($clog2(HOLD_CYCLES + 1) > CNT_W) ||
      ($clog2(REPEAT_CYCLES + 1) > CNT_W)) begin : g_bad_cfg
    $error("stack_btn_ctrl: counter configuration out of range");
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 2);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, HELD = 2'd2, REPEAT = 2'd3} key_state_t;
  logic [CNT_W-1:0] hold_cnt_r [NKEYS];
  logic [CNT_W-1:0] rpt_cnt_r  [NKEYS];
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, HELD = 2'd2} key_state_t;
`endif

  logic [1:0]       raw_s;
  logic [1:0]       pressed_s;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       held_r;
  logic [CNT_W-1:0] db_cnt_r [NKEYS];
  logic [1:0]       rise_s;
  logic [1:0]       req_s;
  key_state_t       state_r [NKEYS];
  logic             push_r;
  logic             pop_r;
  logic             push_pend_r;
  logic             pop_pend_r;

  assign raw_s     = {bus.pop_btn, bus.push_btn};
  assign pressed_s = ~sync2_r;

  // Two-flop synchroniser and debounce: the level flips after a full run of differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
      held_r  <= 2'b00;
      for (int k = 0; k < NKEYS; k++) db_cnt_r[k] <= CNT_ZERO;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int k = 0; k < NKEYS; k++) begin
        if (pressed_s[k] != held_r[k]) begin
          if (db_cnt_r[k] == DB_LAST) begin
            held_r[k]   <= pressed_s[k];
            db_cnt_r[k] <= CNT_ZERO;
          end else begin
            db_cnt_r[k] <= db_cnt_r[k] + CNT_ONE;
          end
        end else begin
          db_cnt_r[k] <= CNT_ZERO;
        end
      end
    end
  end

  // Debounced press edge: the run towards "pressed" completes on this clock.
  always_comb begin
    rise_s = 2'b00;
    for (int k = 0; k < NKEYS; k++) begin
      if (pressed_s[k] && !held_r[k] && (db_cnt_r[k] == DB_LAST)) rise_s[k] = 1'b1;
      else rise_s[k] = 1'b0;
    end
  end

  // Per-key press FSM: one request per press, plus repeat requests while held if enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NKEYS; k++) begin
        state_r[k] <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
        hold_cnt_r[k] <= CNT_ZERO;
        rpt_cnt_r[k]  <= CNT_ZERO;
`endif
      end
    end else begin
      for (int k = 0; k < NKEYS; k++) begin
        case (state_r[k])
          IDLE: begin
            if (rise_s[k]) state_r[k] <= PRESS;
            else state_r[k] <= IDLE;
          end
          PRESS: begin
            state_r[k] <= HELD;
`ifdef BTN_AUTOREPEAT_EN
            hold_cnt_r[k] <= CNT_ZERO;
`endif
          end
          HELD: begin
            if (!held_r[k]) state_r[k] <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
            else if (hold_cnt_r[k] == HOLD_LAST) begin
              state_r[k]   <= REPEAT;
              rpt_cnt_r[k] <= CNT_ZERO;
            end else begin
              hold_cnt_r[k] <= hold_cnt_r[k] + CNT_ONE;
            end
`else
            else state_r[k] <= HELD;
`endif
          end
`ifdef BTN_AUTOREPEAT_EN
          REPEAT: begin
            if (!held_r[k]) state_r[k] <= IDLE;
            else if (rpt_cnt_r[k] == RPT_LAST) rpt_cnt_r[k] <= CNT_ZERO;
            else rpt_cnt_r[k] <= rpt_cnt_r[k] + CNT_ONE;
          end
`endif
          default: state_r[k] <= IDLE;
        endcase
      end
    end
  end

  // Command requests: the press cycle, and each repeat slot while still held.
  always_comb begin
    req_s = 2'b00;
    for (int k = 0; k < NKEYS; k++) begin
      if (state_r[k] == PRESS) req_s[k] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
      else if ((state_r[k] == REPEAT) && held_r[k] && (rpt_cnt_r[k] == CNT_ZERO)) req_s[k] = 1'b1;
`endif
      else req_s[k] = 1'b0;
    end
  end

  // Arbiter: a pending pop goes first, otherwise push wins and a colliding pop waits a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_r      <= 1'b0;
      pop_r       <= 1'b0;
      push_pend_r <= 1'b0;
      pop_pend_r  <= 1'b0;
    end else if (pop_pend_r) begin
      push_r      <= 1'b0;
      pop_r       <= 1'b1;
      push_pend_r <= push_pend_r | req_s[0];
      pop_pend_r  <= 1'b0;
    end else if (push_pend_r | req_s[0]) begin
      push_r      <= 1'b1;
      pop_r       <= 1'b0;
      push_pend_r <= 1'b0;
      pop_pend_r  <= req_s[1];
    end else begin
      push_r      <= 1'b0;
      pop_r       <= req_s[1];
      push_pend_r <= 1'b0;
      pop_pend_r  <= 1'b0;
    end
  end

  assign bus.push      = push_r;
  assign bus.pop       = pop_r;
  assign bus.push_held = held_r[0];
  assign bus.pop_held  = held_r[1];
endmodule

// File: tb/tb_stack_btn_ctrl.sv
// tb_stack_btn_ctrl: directed and randomized key stimulus checked against a
// behavioural model built from the press/debounce/arbitration rules.
module tb_stack_btn_ctrl;
  localparam int D = 4;
  localparam int H = 16;
  localparam int R = 8;
  localparam int MAXE = 8192;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  stack_btn_ctrl_if bus();

  stack_btn_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit raw_h [2][MAXE];
  int edge_n = 0;
  int last_rst = -100;
  bit m_held [2];
  int m_rise [2];
  int m_flip [2];
  bit m_push, m_pop;
  int q[$];

  // Pressed level the debouncer sees at edge m: the raw sample from two edges earlier.
  function automatic bit m_seen(int k, int m);
    if (m < 2 || (m - 2) <= last_rst) return 1'b0;
    return !raw_h[k][m-2];
  endfunction

  task automatic model_edge(bit pb, bit qb, bit rst);
    int e;
    int d;
    bit req [2];
    bit found;
    e = edge_n;
    raw_h[0][e] = pb;
    raw_h[1][e] = qb;
    if (rst) begin
      last_rst = e;
      for (int k = 0; k < 2; k++) begin
        m_held[k] = 1'b0; m_rise[k] = -1; m_flip[k] = e;
      end
      q.delete();
      m_push = 1'b0; m_pop = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        d = e - 1 - m_rise[k];
        req[k] = m_held[k] && (m_rise[k] >= 0) && ((d == 0) || (AR && d >= H && ((d - H) % R) == 0));
      end
      for (int k = 0; k < 2; k++) begin
        if (e - m_flip[k] >= D) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int j = 0; j < D; j++) if (m_seen(k, e - j) == m_held[k]) all_diff = 1'b0;
          if (all_diff) begin
            m_held[k] = !m_held[k];
            m_flip[k] = e;
            m_rise[k] = m_held[k] ? e : -1;
          end
        end
      end
      // Waiting commands go first; new ones join once (push before pop), one issued per cycle.
      for (int c = 0; c < 2; c++) begin
        if (req[c]) begin
          found = 1'b0;
          foreach (q[i]) if (q[i] == c) found = 1'b1;
          if (!found) q.push_back(c);
        end
      end
      m_push = 1'b0; m_pop = 1'b0;
      if (q.size() > 0) begin
        if (q.pop_front() == 0) m_push = 1'b1;
        else m_pop = 1'b1;
      end
    end
    edge_n++;
  endtask

  task automatic tick(bit pb, bit qb, bit rst);
    @(negedge clk);
    bus.push_btn = pb;
    bus.pop_btn  = qb;
    reset        = rst;
    @(posedge clk);
    model_edge(pb, qb, rst);
    #1;
  endtask

  task automatic test_reset();
    int pulses;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      tests++;
      if ({bus.push, bus.pop, bus.push_held, bus.pop_held} !== 4'b0000) begin
        fails++; $display("FAIL reset_state i=%0d got %b want 0000", i, {bus.push, bus.pop, bus.push_held, bus.pop_held});
      end
    end
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tests++;
    if ({bus.push, bus.pop, bus.push_held, bus.pop_held} !== 4'b0000) begin
      fails++; $display("FAIL reset_midpress got %b want 0000", {bus.push, bus.pop, bus.push_held, bus.pop_held});
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (bus.push === 1'b1) pulses++;
      tests++;
      if (bus.push !== (i == 6)) begin
        fails++; $display("FAIL reset_repress i=%0d push got %b want %b", i, bus.push, (i == 6));
      end
    end
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL reset_repress_count got %0d want 1", pulses);
    end
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_single_push();
    int pulses;
    int exp_pulses;
    bit exp_p;
    pulses = 0;
    exp_pulses = AR ? 2 : 1;
    for (int i = 0; i < 30; i++) begin
      tick((i >= 20), 1'b1, 1'b0);
      exp_p = (i == 6) || (AR && i == 22);
      if (bus.push === 1'b1) pulses++;
      tests++;
      if ({bus.push, bus.pop} !== {exp_p, 1'b0}) begin
        fails++; $display("FAIL single_push i=%0d push/pop got %b%b want %b0", i, bus.push, bus.pop, exp_p);
      end
      tests++;
      if ({bus.push, bus.pop, bus.push_held, bus.pop_held} !== {m_push, m_pop, m_held[0], m_held[1]}) begin
        fails++; $display("FAIL single_push_model i=%0d got %b want %b", i,
          {bus.push, bus.pop, bus.push_held, bus.pop_held}, {m_push, m_pop, m_held[0], m_held[1]});
      end
      if (i == 4 || i == 5) begin
        tests++;
        if (bus.push_held !== (i == 5)) begin
          fails++; $display("FAIL single_push_held i=%0d got %b want %b", i, bus.push_held, (i == 5));
        end
      end
    end
    tests++;
    if (pulses != exp_pulses) begin
      fails++; $display("FAIL single_push_count got %0d want %0d", pulses, exp_pulses);
    end
  endtask

  task automatic test_bounce();
    bit pat [6];
    int pulses;
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, pat[i], 1'b0);
      tests++;
      if ({bus.pop, bus.pop_held} !== 2'b00) begin
        fails++; $display("FAIL bounce_quiet i=%0d pop/held got %b%b want 00", i, bus.pop, bus.pop_held);
      end
    end
    pulses = 0;
    for (int i = 0; i < 22; i++) begin
      tick(1'b1, (i >= 12), 1'b0);
      if (bus.pop === 1'b1) pulses++;
      tests++;
      if ({bus.push, bus.pop} !== {1'b0, (i == 6)}) begin
        fails++; $display("FAIL bounce_pop i=%0d push/pop got %b%b want 0%b", i, bus.push, bus.pop, (i == 6));
      end
      tests++;
      if ({bus.push, bus.pop, bus.push_held, bus.pop_held} !== {m_push, m_pop, m_held[0], m_held[1]}) begin
        fails++; $display("FAIL bounce_model i=%0d got %b want %b", i,
          {bus.push, bus.pop, bus.push_held, bus.pop_held}, {m_push, m_pop, m_held[0], m_held[1]});
      end
    end
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL bounce_count got %0d want 1", pulses);
    end
  endtask

  task automatic test_both();
    for (int i = 0; i < 22; i++) begin
      tick((i >= 12), (i >= 12), 1'b0);
      tests++;
      if ({bus.push, bus.pop} !== {(i == 6), (i == 7)}) begin
        fails++; $display("FAIL both_order i=%0d push/pop got %b%b want %b%b", i, bus.push, bus.pop, (i == 6), (i == 7));
      end
      tests++;
      if ({bus.push, bus.pop, bus.push_held, bus.pop_held} !== {m_push, m_pop, m_held[0], m_held[1]}) begin
        fails++; $display("FAIL both_model i=%0d got %b want %b", i,
          {bus.push, bus.pop, bus.push_held, bus.pop_held}, {m_push, m_pop, m_held[0], m_held[1]});
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 13; i++) begin
      tick((i != 0), 1'b1, 1'b0);
      tests++;
      if ({bus.push, bus.push_held} !== 2'b00) begin
        fails++; $display("FAIL glitch i=%0d push/held got %b%b want 00", i, bus.push, bus.push_held);
      end
    end
  endtask

  task automatic test_random();
    bit pb, qb, rst;
    int left_p, left_q;
    pb = 1'b1; qb = 1'b1; left_p = 0; left_q = 0;
    for (int i = 0; i < 1500; i++) begin
      if (left_p == 0) begin pb = ~pb; left_p = $urandom_range(1, 30); end
      if (left_q == 0) begin qb = ~qb; left_q = $urandom_range(1, 30); end
      left_p--; left_q--;
      rst = ($urandom_range(0, 255) == 0);
      tick(pb, qb, rst);
      tests++;
      if ({bus.push, bus.pop, bus.push_held, bus.pop_held} !== {m_push, m_pop, m_held[0], m_held[1]}) begin
        fails++; $display("FAIL random_model i=%0d got %b want %b", i,
          {bus.push, bus.pop, bus.push_held, bus.pop_held}, {m_push, m_pop, m_held[0], m_held[1]});
      end
      tests++;
      if ((bus.push & bus.pop) !== 1'b0) begin
        fails++; $display("FAIL random_exclusive i=%0d push&pop got %b want 0", i, bus.push & bus.pop);
      end
    end
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0);
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat();
    bit exp_p;
    for (int i = 0; i < 80; i++) begin
      tick((i >= 60), 1'b1, 1'b0);
      exp_p = (i == 6) || (i >= 22 && ((i - 22) % R) == 0 && i <= 60 + D + 2);
      tests++;
      if (bus.push !== exp_p) begin
        fails++; $display("FAIL autorepeat i=%0d push got %b want %b", i, bus.push, exp_p);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.push_btn = 1'b1;
    bus.pop_btn  = 1'b1;
    for (int k = 0; k < 2; k++) begin m_held[k] = 1'b0; m_rise[k] = -1; m_flip[k] = -100; end
    m_push = 1'b0; m_pop = 1'b0;
    test_reset();
    test_single_push();
    test_bounce();
    test_both();
    test_glitch();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stack_btn_ctrl.md
# stack_btn_ctrl

Button front end for the 8-entry stack: takes the two raw, bouncing, active-low push/pop keys, synchronises and debounces them, and emits clean single-cycle `push`/`pop` command pulses that the stack consumes directly. It guarantees that push and pop are never asserted together, and that each physical press yields exactly one command. Optional auto-repeat turns a held key into a pulse train.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required before the debounced level changes (≥2).
- `HOLD_CYCLES`, default 16: pressed-hold time before the first repeat pulse. Used only with auto-repeat.
- `REPEAT_CYCLES`, default 8: spacing between repeat pulses. Used only with auto-repeat.
- `CNT_W`, default 8: width of the internal counters; must hold the largest of the three values above.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push_btn`  in  1  raw push key, active-low, asynchronous to `clk`.
- `pop_btn`  in  1  raw pop key, active-low, asynchronous to `clk`.
- `push`  out  1  one-cycle push command, registered.
- `pop`  out  1  one-cycle pop command, registered.
- `push_held`  out  1  debounced push level (1 = pressed).
- `pop_held`  out  1  debounced pop level (1 = pressed).

## Operation
- Per key: a 2-flop synchroniser and an inversion (pressed = 1), feeding a debounce counter.
  - The counter increments while the synchronised level differs from the debounced level.
  - It clears whenever the two are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
- Per-key FSM:
  - `IDLE`: released.
  - `PRESS`: debounced 0→1 seen. Raise a request, then go to `HELD`.
  - `HELD`: stays until debounced release, then returns to `IDLE`.
  - With auto-repeat only, `HELD` leads to `REPEAT` (see Configuration).
- Arbiter registers the outputs from the requests:
  - Push request alone → `push`=1 next cycle.
  - Pop request alone → `pop`=1 next cycle.
  - Both in the same cycle → `push` first. Pop is latched in `pop_pend` and issued the following cycle.
  - A new pop request while `pop_pend` is set merges into it; it is not queued twice.
  - A push request in the cycle `pop_pend` is issued → `pop` is issued and the push is deferred one cycle via `push_pend`.
  - Invariant: `push & pop` = 0 on every cycle.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised samples produce no level change and no pulse.
- Release never generates a command.

## Timing
- Reset values: `push`=0, `pop`=0, `push_held`=0, `pop_held`=0. All counters=0, FSMs=`IDLE`, pend flags=0.
- Synchroniser flops reset to "released".
- Reset asserted mid-press:
  - All state returns to the reset values.
  - After reset deasserts with the key still held, the key debounces as a fresh press and yields one pulse.
- Latency:
  - A raw level is stable before rising edge E0.
  - `*_held` rises after edge E0+1+`DEBOUNCE_CYCLES`.
  - The command pulse is high for exactly the one cycle following edge E0+2+`DEBOUNCE_CYCLES`.
  - A deferred pulse (arbitration loser) comes exactly one cycle later.
- Pulse width is always 1 cycle. Outputs come from flops, so they are stable across the stack's falling-edge sampling.
- Minimum press-to-press spacing: 2×`DEBOUNCE_CYCLES` cycles. A bounce inside that window is filtered.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - In `HELD`, a hold counter runs. After `HOLD_CYCLES` cycles in `HELD`, the FSM enters `REPEAT`.
  - `REPEAT` raises a request every `REPEAT_CYCLES` cycles until debounced release, then returns to `IDLE`.
  - Repeat requests go through the same arbiter.
- `BTN_AUTOREPEAT_EN` undefined:
  - No hold/repeat logic or states are built.
  - `HOLD_CYCLES` and `REPEAT_CYCLES` are ignored.
  - A held key yields exactly one pulse regardless of duration.

## Test plan
Run with DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8.
- Reset held for 3 cycles with both keys released → all outputs 0. Pulse `reset` again mid-press → outputs 0 the next cycle, and one fresh pulse after re-debounce.
- Clean `push_btn` low for 20 cycles → `push_held`=1 from cycle 6. Single `push` pulse in cycle 7. `pop` stays 0. Macro undefined: no further pulses.
- `pop_btn` bouncing (low 2, high 1, low 1, high 2 cycles), then low steady → no pulse during the bounce. Exactly one `pop` pulse, 7 cycles after the steady low begins.
- Both keys pressed on the same edge → `push` in cycle N, `pop` in cycle N+1. `push & pop` never 1.
- Press push for 1 cycle only (glitch shorter than debounce) → no `push`, `push_held` stays 0.
- `BTN_AUTOREPEAT_EN` defined, push held for 60 cycles → first `push` at cycle 7, then pulses 16 cycles later and every 8 cycles after that. Pulses stop within `DEBOUNCE_CYCLES`+2 cycles of release.
